egress_ats_scheduler: RTL and testbench
=======================================

# egress_ats_scheduler

Per-egress-port transmission scheduler for the ATS-capable multi-queue switch. It selects one of NUM_QUEUES priority queues using strict priority among shaper-eligible queues. Each queue has its own token bucket (rate per refill period, burst cap). The block issues a packet grant to the egress datapath, holds it until the datapath reports end of packet, then enforces an inter-frame gap before the next decision.

## Interface
Parameters:
- NUM_QUEUES, 4, number of priority queues; index NUM_QUEUES-1 is highest priority
- QW, clog2(NUM_QUEUES), queue index width
- LEN_WIDTH, 11, head-packet length field in bytes
- RATE_WIDTH, 12, bytes credited per refill tick
- TOKEN_WIDTH, 16, bucket level and burst width
- REFILL_PERIOD, 64, cycles between refill ticks (≥2)
- IFG_CYCLES, 16, idle cycles after each packet (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- q_nonempty  in  NUM_QUEUES  queue i holds at least one complete packet
- q_head_len  in  NUM_QUEUES*LEN_WIDTH  byte length of each queue's head packet; slice i is queue i
- cfg_shaper_en  in  NUM_QUEUES  per-queue shaper enable
- cfg_rate  in  NUM_QUEUES*RATE_WIDTH  tokens added per refill tick
- cfg_burst  in  NUM_QUEUES*TOKEN_WIDTH  bucket cap
- tx_rdy  in  1  egress datapath can accept a new packet
- pkt_done  in  1  single-cycle pulse: eop word of the granted packet transferred
- grant_valid  out  1  a grant is active
- grant_onehot  out  NUM_QUEUES  granted queue, one-hot
- grant_queue  out  QW  granted queue index
- grant_len  out  LEN_WIDTH  byte length latched at the decision
- bucket_level  out  NUM_QUEUES*TOKEN_WIDTH  current token levels

## Operation
- States: IDLE, GRANT, IFG. Reset enters IDLE.
- Eligibility: eligible[i] = q_nonempty[i] && (!cfg_shaper_en[i] || level[i] ≥ head_len[i]).
- IDLE: when tx_rdy=1 and any queue is eligible, pick the highest eligible index, move to GRANT, latch the grant outputs, and deduct head_len from that queue's bucket if its shaper is enabled. Otherwise stay in IDLE.
- GRANT: hold all grant outputs stable. On pkt_done, move to IFG. Changes to q_nonempty, q_head_len, or cfg during GRANT do not affect the current grant.
- IFG: a counter runs from 0 to IFG_CYCLES-1. When it reaches IFG_CYCLES-1, move to IDLE. pkt_done is ignored outside GRANT.
- Refill tick: a free-running counter cycles 0..REFILL_PERIOD-1; a tick occurs when it equals REFILL_PERIOD-1. Ticks occur in every state.
- Bucket update every cycle, computed at TOKEN_WIDTH+1 bits: level' = min(level − deduct + (tick ? rate : 0), burst).
  - The deduction never underflows, because it requires level ≥ len.
  - Lowering cfg_burst clamps the level on the next cycle.
- A queue with the shaper disabled holds level = cfg_burst.

## Timing
- Reset values:
  - grant_valid, grant_onehot, grant_queue, grant_len = 0.
  - All bucket levels = 0; refill counter = 0; IFG counter = 0.
  - Reset mid-GRANT drops the grant on the next edge; no pkt_done is expected afterwards.
- Decision latency: if eligibility and tx_rdy hold at edge t (state IDLE), grant_valid=1 from t+1.
- Release: if pkt_done is seen at edge u, grant_valid=0 from u+1. IFG occupies u+1..u+IFG_CYCLES, IDLE begins at u+IFG_CYCLES+1, and the earliest next grant_valid is at u+IFG_CYCLES+2.
- bucket_level is registered and reflects the deduction one cycle after the decision edge.
- Simultaneous tick and deduction in the same cycle apply both, then clamp.

## Structure
- Shared package (egress_sched_pkg):
  - state enum: IDLE=0, GRANT=1, IFG=2.
  - clog2 function.
  - default widths.
- Sub-module: ats_token_bucket, one per queue via generate.
  - Inputs: tick, deduct_en, deduct_len, shaper_en, rate, burst.
  - Outputs: level, eligible_for(len).
- The top level holds the FSM, priority encoder, refill counter, IFG counter, and grant registers.

## Test plan
- Shapers off, q_nonempty=4'b0101, tx_rdy=1 → grant_queue=2, grant_onehot=4'b0100 one cycle later. pkt_done 10 cycles later → grant_valid low for 17 cycles, then queue 2 is re-granted.
- q3 shaper on, rate=100, burst=1500, head_len=300, from reset → no grant until the third tick (level=300 at cycle 192). Then grant q3 with grant_len=300, and the level reads 0.
- Clamp: rate=1000, burst=1500, idle → level reads 1000 after tick 1 and 1500 after tick 2, never 2000. Then set burst=800 → level reads 800 the next cycle.
- Collision: level=300, len=300, rate=100, decision on a tick cycle → level=100.
- tx_rdy=0 with eligible queues → no grant. A pkt_done pulse in IDLE or IFG → no state change.
- Reset asserted mid-GRANT → all outputs and levels 0 next cycle. After release, the first grant follows the normal rules.

Source files
------------

// File: rtl/egress_sched_pkg.sv
// Shared state encoding, default widths and a width helper for the egress ATS scheduler.
package egress_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        IFG   = 2'd2
    } sched_state_e;

    localparam int DEF_NUM_QUEUES    = 4;
    localparam int DEF_LEN_WIDTH     = 11;
    localparam int DEF_RATE_WIDTH    = 12;
    localparam int DEF_TOKEN_WIDTH   = 16;
    localparam int DEF_REFILL_PERIOD = 64;
    localparam int DEF_IFG_CYCLES    = 16;

    // Never returns 0 so it can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction
endpackage

// File: rtl/egress_ats_scheduler_if.sv
// Queue status, shaper configuration, datapath handshake and grant outputs of one egress port.
interface egress_ats_scheduler_if
    import egress_sched_pkg::*;
#(
    parameter int NUM_QUEUES  = DEF_NUM_QUEUES,
    parameter int QW          = clog2(NUM_QUEUES),
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int RATE_WIDTH  = DEF_RATE_WIDTH,
    parameter int TOKEN_WIDTH = DEF_TOKEN_WIDTH
);
    logic [NUM_QUEUES-1:0]             q_nonempty;
    logic [NUM_QUEUES*LEN_WIDTH-1:0]   q_head_len;
    logic [NUM_QUEUES-1:0]             cfg_shaper_en;
    logic [NUM_QUEUES*RATE_WIDTH-1:0]  cfg_rate;
    logic [NUM_QUEUES*TOKEN_WIDTH-1:0] cfg_burst;
    logic                              tx_rdy;
    logic                              pkt_done;
    logic                              grant_valid;
    logic [NUM_QUEUES-1:0]             grant_onehot;
    logic [QW-1:0]                     grant_queue;
    logic [LEN_WIDTH-1:0]              grant_len;
    logic [NUM_QUEUES*TOKEN_WIDTH-1:0] bucket_level;

    modport master (
        output q_nonempty, q_head_len, cfg_shaper_en, cfg_rate, cfg_burst, tx_rdy, pkt_done,
        input  grant_valid, grant_onehot, grant_queue, grant_len, bucket_level
    );

    modport slave (
        input  q_nonempty, q_head_len, cfg_shaper_en, cfg_rate, cfg_burst, tx_rdy, pkt_done,
        output grant_valid, grant_onehot, grant_queue, grant_len, bucket_level
    );
endinterface

// File: rtl/ats_token_bucket.sv
// Per-queue token bucket: registered level with deduction, periodic refill and burst clamp.
module ats_token_bucket #(
    parameter int LEN_WIDTH   = 11,
    parameter int RATE_WIDTH  = 12,
    parameter int TOKEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_i,
    input  logic                   deduct_en_i,
    input  logic [LEN_WIDTH-1:0]   deduct_len_i,
    input  logic                   shaper_en_i,
    input  logic [RATE_WIDTH-1:0]  rate_i,
    input  logic [TOKEN_WIDTH-1:0] burst_i,
    output logic [TOKEN_WIDTH-1:0] level_o,
    output logic                   eligible_o
);
    typedef logic [TOKEN_WIDTH:0] wide_t;

    logic [TOKEN_WIDTH-1:0] level_q, level_d;
    wide_t                  sum;

    // deduct_len_i is the head length, so it doubles as the eligibility threshold.
    always_comb begin
        sum = wide_t'(level_q)
            - (deduct_en_i ? wide_t'(deduct_len_i) : '0)
            + (tick_i ? wide_t'(rate_i) : '0);
        if (!shaper_en_i) begin
            level_d = burst_i;
        end else if (sum > wide_t'(burst_i)) begin
            level_d = burst_i;
        end else begin
            level_d = sum[TOKEN_WIDTH-1:0];
        end
        eligible_o = !shaper_en_i || (wide_t'(level_q) >= wide_t'(deduct_len_i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/egress_ats_scheduler.sv
// Egress ATS scheduler: strict priority among shaper-eligible queues, grant hold until
// end of packet, then a fixed inter-frame gap before the next decision.
module egress_ats_scheduler
    import egress_sched_pkg::*;
#(
    parameter int NUM_QUEUES    = DEF_NUM_QUEUES,
    parameter int QW            = clog2(NUM_QUEUES),
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter int RATE_WIDTH    = DEF_RATE_WIDTH,
    parameter int TOKEN_WIDTH   = DEF_TOKEN_WIDTH,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD,
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES
) (
    input logic                   clk,
    input logic                   reset,
    egress_ats_scheduler_if.slave bus
);
    localparam int              RW          = clog2(REFILL_PERIOD);
    localparam int              IW          = clog2(IFG_CYCLES);
    localparam logic [RW-1:0]   REFILL_LAST = RW'(REFILL_PERIOD - 1);
    localparam logic [IW-1:0]   IFG_LAST    = IW'(IFG_CYCLES - 1);

    sched_state_e                      state_q, state_d;
    logic [RW-1:0]                     refill_cnt_q;
    logic [IW-1:0]                     ifg_cnt_q, ifg_cnt_d;
    logic                              grant_valid_q, grant_valid_d;
    logic [NUM_QUEUES-1:0]             grant_onehot_q, grant_onehot_d;
    logic [QW-1:0]                     grant_queue_q, grant_queue_d;
    logic [LEN_WIDTH-1:0]              grant_len_q, grant_len_d;
    logic                              tick;
    logic [NUM_QUEUES-1:0]             shaper_ok, eligible, deduct_en;
    logic [NUM_QUEUES*TOKEN_WIDTH-1:0] levels;
    logic                              pick_any;
    logic [QW-1:0]                     pick_idx;
    logic [LEN_WIDTH-1:0]              pick_len;

    assign tick     = (refill_cnt_q == REFILL_LAST);
    assign eligible = bus.q_nonempty & shaper_ok;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_bucket
        ats_token_bucket #(
            .LEN_WIDTH  (LEN_WIDTH),
            .RATE_WIDTH (RATE_WIDTH),
            .TOKEN_WIDTH(TOKEN_WIDTH)
        ) u_bucket (
            .clk         (clk),
            .reset       (reset),
            .tick_i      (tick),
            .deduct_en_i (deduct_en[i]),
            .deduct_len_i(bus.q_head_len[i*LEN_WIDTH +: LEN_WIDTH]),
            .shaper_en_i (bus.cfg_shaper_en[i]),
            .rate_i      (bus.cfg_rate[i*RATE_WIDTH +: RATE_WIDTH]),
            .burst_i     (bus.cfg_burst[i*TOKEN_WIDTH +: TOKEN_WIDTH]),
            .level_o     (levels[i*TOKEN_WIDTH +: TOKEN_WIDTH]),
            .eligible_o  (shaper_ok[i])
        );
    end

    // Ascending scan: the last eligible index seen is the highest priority.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        pick_len = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (eligible[i]) begin
                pick_any = 1'b1;
                pick_idx = QW'(i);
                pick_len = bus.q_head_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // IDLE: awaiting decision | GRANT: holding until pkt_done | IFG: gap countdown
    always_comb begin
        state_d        = state_q;
        ifg_cnt_d      = ifg_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_onehot_d = grant_onehot_q;
        grant_queue_d  = grant_queue_q;
        grant_len_d    = grant_len_q;
        deduct_en      = '0;
        case (state_q)
            IDLE: begin
                if (bus.tx_rdy && pick_any) begin
                    state_d             = GRANT;
                    grant_valid_d       = 1'b1;
                    grant_onehot_d      = NUM_QUEUES'(1) << pick_idx;
                    grant_queue_d       = pick_idx;
                    grant_len_d         = pick_len;
                    deduct_en[pick_idx] = bus.cfg_shaper_en[pick_idx];
                end
            end
            GRANT: begin
                if (bus.pkt_done) begin
                    state_d        = IFG;
                    ifg_cnt_d      = '0;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    grant_queue_d  = '0;
                    grant_len_d    = '0;
                end
            end
            IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d   = IDLE;
                    ifg_cnt_d = '0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            refill_cnt_q   <= '0;
            ifg_cnt_q      <= '0;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_queue_q  <= '0;
            grant_len_q    <= '0;
        end else begin
            state_q        <= state_d;
            refill_cnt_q   <= tick ? '0 : refill_cnt_q + 1'b1;
            ifg_cnt_q      <= ifg_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_onehot_q <= grant_onehot_d;
            grant_queue_q  <= grant_queue_d;
            grant_len_q    <= grant_len_d;
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.grant_queue  = grant_queue_q;
    assign bus.grant_len    = grant_len_q;
    assign bus.bucket_level = levels;
endmodule

// File: tb/tb_egress_ats_scheduler.sv
// Scoreboard bench for egress_ats_scheduler: directed scenarios plus randomized traffic,
// checked against a cycle-level arithmetic model of the buckets and grant rules.
module tb_egress_ats_scheduler;
    localparam int NQ = 4, QW = 2, LW = 11, RW = 12, TW = 16;
    localparam int REFILL = 64, IFG = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    egress_ats_scheduler_if #(.NUM_QUEUES(NQ), .QW(QW), .LEN_WIDTH(LW),
                              .RATE_WIDTH(RW), .TOKEN_WIDTH(TW)) bus ();

    egress_ats_scheduler #(.NUM_QUEUES(NQ), .QW(QW), .LEN_WIDTH(LW), .RATE_WIDTH(RW),
                           .TOKEN_WIDTH(TW), .REFILL_PERIOD(REFILL), .IFG_CYCLES(IFG)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { int q; int len; } exp_t;
    exp_t sb[$];

    int m_level[NQ];
    int m_c         = 0;
    bit m_granted   = 0;
    int m_idle_from = 0;
    bit mon_en      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic of the shaping and grant rules per clock.
    initial begin : model
        int  pick, v, len;
        bit  tick;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NQ; i++) m_level[i] = 0;
                m_c = 0; m_granted = 0; m_idle_from = 0;
                sb.delete();
            end else begin
                tick = ((m_c % REFILL) == REFILL - 1);
                pick = -1;
                if (!m_granted && m_c >= m_idle_from && bus.tx_rdy)
                    for (int i = 0; i < NQ; i++)
                        if (bus.q_nonempty[i] && (!bus.cfg_shaper_en[i] ||
                            m_level[i] >= int'(bus.q_head_len[i*LW +: LW]))) pick = i;
                if (m_granted && bus.pkt_done) begin
                    m_granted   = 0;
                    m_idle_from = m_c + IFG + 1;
                end else if (pick >= 0) begin
                    m_granted = 1;
                    sb.push_back('{q: pick, len: int'(bus.q_head_len[pick*LW +: LW])});
                end
                for (int i = 0; i < NQ; i++) begin
                    if (!bus.cfg_shaper_en[i]) begin
                        m_level[i] = int'(bus.cfg_burst[i*TW +: TW]);
                    end else begin
                        len = (i == pick) ? int'(bus.q_head_len[i*LW +: LW]) : 0;
                        v   = m_level[i] - len + (tick ? int'(bus.cfg_rate[i*RW +: RW]) : 0);
                        m_level[i] = (v > int'(bus.cfg_burst[i*TW +: TW])) ?
                                     int'(bus.cfg_burst[i*TW +: TW]) : v;
                    end
                end
                m_c++;
            end
        end
    end

    initial begin : monitor
        logic [NQ*TW-1:0] exp_lv;
        logic             prev_gv;
        exp_t             cur;
        prev_gv = 1'b0;
        cur     = '{q: 0, len: 0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < NQ; i++) exp_lv[i*TW +: TW] = TW'(m_level[i]);
                check("grant_valid", 64'(bus.grant_valid), 64'(m_granted));
                check("bucket_level", 64'(bus.bucket_level), 64'(exp_lv));
                if (bus.grant_valid && !prev_gv) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_unexpected: got queue %0d want none", bus.grant_queue);
                    end else begin
                        cur = sb.pop_front();
                        check("sb_queue", 64'(bus.grant_queue), 64'(cur.q));
                        check("sb_onehot", 64'(bus.grant_onehot), 64'(1) << cur.q);
                        check("sb_len", 64'(bus.grant_len), 64'(cur.len));
                    end
                end else if (bus.grant_valid && prev_gv) begin
                    check("hold_queue", 64'(bus.grant_queue), 64'(cur.q));
                    check("hold_len", 64'(bus.grant_len), 64'(cur.len));
                end
                prev_gv = bus.grant_valid;
            end
        end
    end

    task automatic set_q(input int q, input bit en, input int rate, input int burst, input int len);
        bus.cfg_shaper_en[q]         = en;
        bus.cfg_rate[q*RW +: RW]     = RW'(rate);
        bus.cfg_burst[q*TW +: TW]    = TW'(burst);
        bus.q_head_len[q*LW +: LW]   = LW'(len);
    endtask

    task automatic start_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.pkt_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_done();
        bus.pkt_done = 1'b1;
        @(negedge clk);
        bus.pkt_done = 1'b0;
    endtask

    task automatic count_low(input string name, input int exp_low, input int exp_q);
        int n;
        n = 0;
        while (bus.grant_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_low_cycles"}, 64'(n), 64'(exp_low));
        check({name, "_regrant_q"}, 64'(bus.grant_queue), 64'(exp_q));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bus.q_nonempty = '0; bus.q_head_len = '0; bus.cfg_shaper_en = '0;
        bus.cfg_rate = '0; bus.cfg_burst = '0; bus.tx_rdy = 1'b0; bus.pkt_done = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("reset_valid", 64'(bus.grant_valid), 64'd0);
        check("reset_level", 64'(bus.bucket_level), 64'd0);

        // Shapers off, strict priority and IFG spacing
        for (int q = 0; q < NQ; q++) set_q(q, 0, 0, 1500, 100);
        bus.q_nonempty = 4'b0101; bus.tx_rdy = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("t1_valid", 64'(bus.grant_valid), 64'd1);
        check("t1_queue", 64'(bus.grant_queue), 64'd2);
        check("t1_onehot", 64'(bus.grant_onehot), 64'b0100);
        repeat (9) @(negedge clk);
        pulse_done();
        count_low("t1", IFG + 1, 2);

        // Single shaped queue: first grant waits for the third refill
        start_reset();
        for (int q = 0; q < NQ; q++) set_q(q, 0, 0, 0, 0);
        set_q(3, 1, 100, 1500, 300);
        bus.q_nonempty = 4'b1000; bus.tx_rdy = 1'b1;
        reset = 1'b0;
        n = 0;
        while (bus.grant_valid !== 1'b1 && n < 400) begin n++; @(negedge clk); end
        check("t2_latency", 64'(n), 64'd193);
        check("t2_queue", 64'(bus.grant_queue), 64'd3);
        check("t2_len", 64'(bus.grant_len), 64'd300);
        check("t2_level", 64'(bus.bucket_level[3*TW +: TW]), 64'd0);
        pulse_done();

        // Burst clamp and lowering burst
        start_reset();
        for (int q = 0; q < NQ; q++) set_q(q, 0, 0, 0, 0);
        set_q(0, 1, 1000, 1500, 100);
        bus.q_nonempty = '0;
        reset = 1'b0;
        repeat (64) @(negedge clk);
        check("t3_tick1", 64'(bus.bucket_level[0 +: TW]), 64'd1000);
        repeat (64) @(negedge clk);
        check("t3_tick2", 64'(bus.bucket_level[0 +: TW]), 64'd1500);
        repeat (64) @(negedge clk);
        check("t3_tick3", 64'(bus.bucket_level[0 +: TW]), 64'd1500);
        bus.cfg_burst[0 +: TW] = 16'd800;
        @(negedge clk);
        check("t3_lower_burst", 64'(bus.bucket_level[0 +: TW]), 64'd800);

        // Deduction and refill in the same cycle
        start_reset();
        for (int q = 0; q < NQ; q++) set_q(q, 0, 0, 0, 0);
        set_q(3, 1, 100, 300, 300);
        bus.q_nonempty = '0; bus.tx_rdy = 1'b1;
        reset = 1'b0;
        repeat (255) @(negedge clk);
        check("t4_pre_level", 64'(bus.bucket_level[3*TW +: TW]), 64'd300);
        bus.q_nonempty = 4'b1000;
        @(negedge clk);
        check("t4_valid", 64'(bus.grant_valid), 64'd1);
        check("t4_level", 64'(bus.bucket_level[3*TW +: TW]), 64'd100);
        pulse_done();

        // tx_rdy low blocks grants; stray pkt_done in IDLE and IFG is ignored
        start_reset();
        for (int q = 0; q < NQ; q++) set_q(q, 0, 0, 500, 64 + q);
        bus.q_nonempty = 4'b1111; bus.tx_rdy = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_no_grant", 64'(bus.grant_valid), 64'd0);
            bus.pkt_done = (i == 4);
        end
        bus.pkt_done = 1'b0; bus.tx_rdy = 1'b1;
        @(negedge clk);
        check("t5_queue", 64'(bus.grant_queue), 64'd3);
        check("t5_len", 64'(bus.grant_len), 64'd67);
        pulse_done();
        repeat (4) @(negedge clk);
        pulse_done();
        count_low("t5", IFG + 1 - 5, 3);

        // Reset while a grant is held
        reset = 1'b1;
        @(negedge clk);
        check("t6_valid", 64'(bus.grant_valid), 64'd0);
        check("t6_onehot", 64'(bus.grant_onehot), 64'd0);
        check("t6_queue", 64'(bus.grant_queue), 64'd0);
        check("t6_len", 64'(bus.grant_len), 64'd0);
        check("t6_level", 64'(bus.bucket_level), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_regrant", 64'(bus.grant_valid), 64'd1);
        check("t6_regrant_q", 64'(bus.grant_queue), 64'd3);

        // Randomized traffic against the model
        start_reset();
        for (int q = 0; q < NQ; q++)
            set_q(q, 1'($urandom), $urandom_range(10, 400), $urandom_range(200, 2500),
                  $urandom_range(40, 600));
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.q_nonempty = NQ'($urandom);
            for (int q = 0; q < NQ; q++)
                bus.q_head_len[q*LW +: LW] = LW'($urandom_range(40, 600));
            if ($urandom_range(0, 31) == 0)
                for (int q = 0; q < NQ; q++)
                    set_q(q, 1'($urandom), $urandom_range(10, 400), $urandom_range(200, 2500),
                          int'(bus.q_head_len[q*LW +: LW]));
            bus.tx_rdy   = ($urandom_range(0, 3) != 0);
            bus.pkt_done = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        bus.pkt_done = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
